// File: rtl/abstract_cmd_executor_pkg.sv
// -----------------------------------------------------------------------------
// DM package: shared debug-module types for the abstract command executor.
//
// Contents:
//   MaxAar        - first aarsize encoding this 32-bit debug module cannot
//                   service (3 = 64-bit access).
//   cmdtype_e     - abstract command type field of the `command` register.
//   command_t     - raw layout of the `command` register.
//   cmderr_e      - abstractcs.cmderr encodings.
//   size_extend() - keeps the low 8/16/32 bits of a word selected by aarsize
//                   and zero-fills the rest.
// -----------------------------------------------------------------------------
package DM;

    localparam int unsigned MaxAar = 3;

    typedef enum logic [7:0] {
        AccessRegister = 8'h00,
        QuickAccess    = 8'h01,
        AccessMemory   = 8'h02
    } cmdtype_e;

    typedef struct packed {
        cmdtype_e    cmdtype;
        logic [23:0] control;
    } command_t;

    typedef enum logic [2:0] {
        NONE       = 3'd0,
        BUSY       = 3'd1,
        NOTSUP     = 3'd2,
        EXCEPTION  = 3'd3,
        HALTRESUME = 3'd4,
        BUS        = 3'd5,
        OTHER      = 3'd7
    } cmderr_e;

    // The same operation serves as write-data masking and read-data
    // zero-extension, since both keep only the low aarsize bytes.
    function automatic logic [31:0] size_extend(input logic [31:0] value,
                                                input logic [2:0]  size);
        logic [31:0] result;
        case (size)
            3'd0:    result = {24'h000000, value[7:0]};
            3'd1:    result = {16'h0000, value[15:0]};
            default: result = value;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/abstract_cmd_executor_if.sv
// -----------------------------------------------------------------------------
// abstract_cmd_executor_if: hart-side port of the abstract command executor.
//
// Register access port:
//   reg_req / reg_we / reg_addr / reg_wdata   executor -> hart
//   reg_gnt / reg_rvalid / reg_err / reg_rdata hart -> executor
// Program-buffer execution port:
//   exec_req                                   executor -> hart
//   exec_ack / exec_done / exec_exception      hart -> executor
//
// Modports: master = executor side, slave = hart side.
// -----------------------------------------------------------------------------
interface abstract_cmd_executor_if;

    logic        reg_req;
    logic        reg_we;
    logic [15:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_gnt;
    logic        reg_rvalid;
    logic        reg_err;
    logic [31:0] reg_rdata;

    logic        exec_req;
    logic        exec_ack;
    logic        exec_done;
    logic        exec_exception;

    modport master (
        output reg_req, reg_we, reg_addr, reg_wdata, exec_req,
        input  reg_gnt, reg_rvalid, reg_err, reg_rdata,
        input  exec_ack, exec_done, exec_exception
    );

    modport slave (
        input  reg_req, reg_we, reg_addr, reg_wdata, exec_req,
        output reg_gnt, reg_rvalid, reg_err, reg_rdata,
        output exec_ack, exec_done, exec_exception
    );

endinterface

// File: rtl/abstract_cmd_executor.sv
// -----------------------------------------------------------------------------
// abstract_cmd_executor: runs decoded Access Register abstract commands.
//
// Owns abstractcs.busy / abstractcs.cmderr. An accepted command performs one
// register transfer through the hart register port, optionally launches
// program-buffer execution, and writes read data back into data0.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cmd_valid_i ..        decoded command (type, aarsize, postexec, transfer,
//   unsupported_i         write, regno) and decoder "unsupported" verdict
//   hart_halted_i         selected hart is halted
//   dmi_busy_access_i     DMI touched data/progbuf/command while busy
//   cmderr_clear_i        W1C mask from an abstractcs write
//   data0_i / data0_o     current data0 / write-back value
//   data0_we_o            one-cycle write-back strobe
//   busy_o, cmderr_o      abstractcs status
//   hart_port             register access and program-buffer execution port
// All outputs are registered.
// -----------------------------------------------------------------------------
module abstract_cmd_executor
    import DM::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    cmd_valid_i,
    input  cmdtype_e                cmd_type_i,
    input  logic [2:0]              aarsize_i,
    input  logic                    postexec_i,
    input  logic                    transfer_i,
    input  logic                    write_i,
    input  logic [15:0]             regno_i,
    input  logic                    unsupported_i,
    input  logic                    hart_halted_i,
    input  logic                    dmi_busy_access_i,
    input  logic [2:0]              cmderr_clear_i,

    input  logic [31:0]             data0_i,
    output logic [31:0]             data0_o,
    output logic                    data0_we_o,
    output logic                    busy_o,
    output logic [2:0]              cmderr_o,

    abstract_cmd_executor_if.master hart_port
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StResp,
        StExec,
        StWait
    } state_e;

    state_e      state_q, state_d;

    logic        write_q, write_d;
    logic        postexec_q, postexec_d;
    logic [2:0]  aarsize_q, aarsize_d;
    logic [15:0] regno_q, regno_d;

    logic        busy_q, busy_d;
    logic [2:0]  cmderr_q, cmderr_d;
    logic        reg_req_q, reg_req_d;
    logic        reg_we_q, reg_we_d;
    logic [15:0] reg_addr_q, reg_addr_d;
    logic [31:0] reg_wdata_q, reg_wdata_d;
    logic        exec_req_q, exec_req_d;
    logic [31:0] data0_q, data0_d;
    logic        data0_we_q, data0_we_d;

    cmderr_e     err_set;
    logic        cmd_unsupported;

    // Anything other than a 32-bit-or-narrower Access Register is refused.
    assign cmd_unsupported = unsupported_i
                           || (cmd_type_i != AccessRegister)
                           || (transfer_i && (aarsize_i >= 3'(MaxAar)));

    // State register plus every registered output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            postexec_q  <= 1'b0;
            aarsize_q   <= 3'd0;
            regno_q     <= 16'h0000;
            busy_q      <= 1'b0;
            cmderr_q    <= 3'd0;
            reg_req_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= 16'h0000;
            reg_wdata_q <= 32'h0000_0000;
            exec_req_q  <= 1'b0;
            data0_q     <= 32'h0000_0000;
            data0_we_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            postexec_q  <= postexec_d;
            aarsize_q   <= aarsize_d;
            regno_q     <= regno_d;
            busy_q      <= busy_d;
            cmderr_q    <= cmderr_d;
            reg_req_q   <= reg_req_d;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            exec_req_q  <= exec_req_d;
            data0_q     <= data0_d;
            data0_we_q  <= data0_we_d;
        end
    end

    // Next-state logic. Command fields are latched only on acceptance, so a
    // command arriving while busy can never disturb the running one.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        postexec_d = postexec_q;
        aarsize_d  = aarsize_q;
        regno_d    = regno_q;
        err_set    = NONE;

        case (state_q)
            StIdle: begin
                if (cmd_valid_i && (cmderr_q == NONE)) begin
                    if (cmd_unsupported) begin
                        err_set = NOTSUP;
                    end else if (!hart_halted_i) begin
                        err_set = HALTRESUME;
                    end else if (transfer_i) begin
                        state_d    = StReq;
                        write_d    = write_i;
                        postexec_d = postexec_i;
                        aarsize_d  = aarsize_i;
                        regno_d    = regno_i;
                    end else if (postexec_i) begin
                        state_d = StExec;
                    end
                end
            end
            StReq: begin
                if (reg_req_q && hart_port.reg_gnt) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (hart_port.reg_rvalid) begin
                    if (hart_port.reg_err) begin
                        err_set = EXCEPTION;
                        state_d = StIdle;
                    end else if (postexec_q) begin
                        state_d = StExec;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StExec: begin
                if (exec_req_q && hart_port.exec_ack) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (hart_port.exec_done) begin
                    state_d = StIdle;
                    if (hart_port.exec_exception) begin
                        err_set = EXCEPTION;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A hart-reported fault in the same cycle takes precedence over a busy hit.
        if ((state_q != StIdle) && (cmd_valid_i || dmi_busy_access_i)
                && (err_set == NONE)) begin
            err_set = BUSY;
        end
    end

    // Output logic: registered outputs are derived from the next state so they
    // line up with the state they describe.
    always_comb begin
        busy_d      = (state_d != StIdle);
        reg_req_d   = (state_d == StReq);
        reg_we_d    = reg_req_d && write_d;
        reg_addr_d  = reg_req_d ? regno_d : 16'h0000;
        reg_wdata_d = reg_req_d ? size_extend(data0_i, aarsize_d) : 32'h0000_0000;
        exec_req_d  = (state_d == StExec);

        data0_we_d  = (state_q == StResp) && hart_port.reg_rvalid
                    && !hart_port.reg_err && !write_q;
        data0_d     = data0_we_d ? size_extend(hart_port.reg_rdata, aarsize_q)
                                 : data0_q;

        // Clear first, then a fresh error wins over the clear; an existing
        // error is never replaced by another one.
        cmderr_d = cmderr_q & ~cmderr_clear_i;
        if ((err_set != NONE) && (cmderr_q == NONE)) begin
            cmderr_d = err_set;
        end
    end

    assign busy_o     = busy_q;
    assign cmderr_o   = cmderr_q;
    assign data0_o    = data0_q;
    assign data0_we_o = data0_we_q;

    assign hart_port.reg_req   = reg_req_q;
    assign hart_port.reg_we    = reg_we_q;
    assign hart_port.reg_addr  = reg_addr_q;
    assign hart_port.reg_wdata = reg_wdata_q;
    assign hart_port.exec_req  = exec_req_q;

endmodule

// File: tb/tb_abstract_cmd_executor.sv
// -----------------------------------------------------------------------------
// tb_abstract_cmd_executor: self-checking bench for abstract_cmd_executor.
// Inputs change 1 ns after the rising edge; direct checks are made there too.
// Expected data0 write-backs are queued when a read is driven and popped by a
// falling-edge monitor whenever the DUT strobes data0_we_o.
// -----------------------------------------------------------------------------
module tb_abstract_cmd_executor;
    import DM::*;

    logic        clk;
    logic        rst;
    logic        cmdValid;
    cmdtype_e    cmdType;
    logic [2:0]  aarSize;
    logic        postExec;
    logic        transfer;
    logic        writeCmd;
    logic [15:0] regNo;
    logic        unsupported;
    logic        hartHalted;
    logic        dmiBusyAccess;
    logic [2:0]  cmderrClear;
    logic [31:0] data0In;
    logic [31:0] data0Out;
    logic        data0We;
    logic        busy;
    logic [2:0]  cmderr;

    int checkCount   = 0;
    int failureCount = 0;

    logic [31:0] expectedData0[$];

    abstract_cmd_executor_if hartIf();

    abstract_cmd_executor dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .cmd_valid_i       (cmdValid),
        .cmd_type_i        (cmdType),
        .aarsize_i         (aarSize),
        .postexec_i        (postExec),
        .transfer_i        (transfer),
        .write_i           (writeCmd),
        .regno_i           (regNo),
        .unsupported_i     (unsupported),
        .hart_halted_i     (hartHalted),
        .dmi_busy_access_i (dmiBusyAccess),
        .cmderr_clear_i    (cmderrClear),
        .data0_i           (data0In),
        .data0_o           (data0Out),
        .data0_we_o        (data0We),
        .busy_o            (busy),
        .cmderr_o          (cmderr),
        .hart_port         (hartIf)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failureCount++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle command pulse; returns at cycle N+1.
    task automatic applyStimulus(input logic xfer, input logic post, input logic wr,
                                 input logic [2:0] size, input logic [15:0] regnum);
        transfer = xfer;
        postExec = post;
        writeCmd = wr;
        aarSize  = size;
        regNo    = regnum;
        cmdValid = 1'b1;
        tick();
        cmdValid = 1'b0;
    endtask

    // Clear all cmderr bits for one cycle.
    task automatic clearErrors();
        cmderrClear = 3'b111;
        tick();
        cmderrClear = 3'b000;
    endtask

    // Scoreboard side: each data0 write-back must match the oldest queued read.
    always @(negedge clk) begin
        if (!rst && data0We) begin
            if (expectedData0.size() == 0) begin
                checkOutput("unexpected_data0_we", 32'd1, 32'd0);
            end else begin
                checkOutput("data0_writeback", data0Out, expectedData0.pop_front());
            end
        end
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] time limit reached");
    end

    // Main stimulus sequence.
    initial begin
        rst                   = 1'b1;
        cmdValid              = 1'b0;
        cmdType               = AccessRegister;
        aarSize               = 3'd2;
        postExec              = 1'b0;
        transfer              = 1'b0;
        writeCmd              = 1'b0;
        regNo                 = 16'h0000;
        unsupported           = 1'b0;
        hartHalted            = 1'b1;
        dmiBusyAccess         = 1'b0;
        cmderrClear           = 3'b000;
        data0In               = 32'h0000_0000;
        hartIf.reg_gnt        = 1'b0;
        hartIf.reg_rvalid     = 1'b0;
        hartIf.reg_err        = 1'b0;
        hartIf.reg_rdata      = 32'h0000_0000;
        hartIf.exec_ack       = 1'b0;
        hartIf.exec_done      = 1'b0;
        hartIf.exec_exception = 1'b0;

        tick();
        tick();
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_cmderr", {29'd0, cmderr}, 32'd0);
        checkOutput("reset_reg_req", {31'd0, hartIf.reg_req}, 32'd0);
        checkOutput("reset_exec_req", {31'd0, hartIf.exec_req}, 32'd0);
        checkOutput("reset_data0", data0Out, 32'd0);
        rst = 1'b0;
        tick();

        // 32-bit read of 0x1001 through a zero-wait register port.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd2, 16'h1001);
        checkOutput("rd_busy_n1", {31'd0, busy}, 32'd1);
        checkOutput("rd_req_n1", {31'd0, hartIf.reg_req}, 32'd1);
        checkOutput("rd_addr", {16'd0, hartIf.reg_addr}, 32'h0000_1001);
        checkOutput("rd_we", {31'd0, hartIf.reg_we}, 32'd0);
        hartIf.reg_gnt = 1'b1;
        tick();
        hartIf.reg_gnt = 1'b0;
        checkOutput("rd_busy_n2", {31'd0, busy}, 32'd1);
        checkOutput("rd_req_dropped", {31'd0, hartIf.reg_req}, 32'd0);
        hartIf.reg_rvalid = 1'b1;
        hartIf.reg_rdata  = 32'hDEAD_BEEF;
        expectedData0.push_back(32'hDEAD_BEEF);
        tick();
        hartIf.reg_rvalid = 1'b0;
        checkOutput("rd_busy_n3", {31'd0, busy}, 32'd0);
        checkOutput("rd_we_n3", {31'd0, data0We}, 32'd1);
        tick();
        checkOutput("rd_we_pulse", {31'd0, data0We}, 32'd0);

        // Byte write; a busy access while waiting for grant flags BUSY only.
        data0In = 32'h1234_5678;
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 16'h1002);
        checkOutput("wr_wdata", hartIf.reg_wdata, 32'h0000_0078);
        checkOutput("wr_we", {31'd0, hartIf.reg_we}, 32'd1);
        dmiBusyAccess = 1'b1;
        tick();
        dmiBusyAccess = 1'b0;
        checkOutput("wr_busy_err", {29'd0, cmderr}, 32'd1);
        checkOutput("wr_req_stable", {31'd0, hartIf.reg_req}, 32'd1);
        checkOutput("wr_addr_stable", {16'd0, hartIf.reg_addr}, 32'h0000_1002);
        hartIf.reg_gnt = 1'b1;
        tick();
        hartIf.reg_gnt    = 1'b0;
        hartIf.reg_rvalid = 1'b1;
        hartIf.reg_rdata  = 32'hFFFF_FFFF;
        tick();
        hartIf.reg_rvalid = 1'b0;
        checkOutput("wr_done_busy", {31'd0, busy}, 32'd0);
        checkOutput("wr_no_data0_we", {31'd0, data0We}, 32'd0);
        clearErrors();
        checkOutput("wr_err_cleared", {29'd0, cmderr}, 32'd0);

        // Command while the hart runs is refused; later commands are ignored.
        hartHalted = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd2, 16'h1001);
        checkOutput("halt_cmderr", {29'd0, cmderr}, 32'd4);
        checkOutput("halt_busy", {31'd0, busy}, 32'd0);
        hartHalted = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd2, 16'h1001);
        checkOutput("ignored_busy", {31'd0, busy}, 32'd0);
        checkOutput("ignored_req", {31'd0, hartIf.reg_req}, 32'd0);
        checkOutput("ignored_cmderr", {29'd0, cmderr}, 32'd4);
        clearErrors();
        checkOutput("halt_cleared", {29'd0, cmderr}, 32'd0);

        // Unsupported command yields NOTSUP without going busy.
        unsupported = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd2, 16'h1001);
        unsupported = 1'b0;
        checkOutput("notsup_cmderr", {29'd0, cmderr}, 32'd2);
        checkOutput("notsup_busy", {31'd0, busy}, 32'd0);
        clearErrors();

        // 16-bit read with postexec; execution faults.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd1, 16'h1003);
        hartIf.reg_gnt = 1'b1;
        tick();
        hartIf.reg_gnt    = 1'b0;
        hartIf.reg_rvalid = 1'b1;
        hartIf.reg_rdata  = 32'hCAFE_F00D;
        expectedData0.push_back(32'h0000_F00D);
        tick();
        hartIf.reg_rvalid = 1'b0;
        checkOutput("pe_exec_req", {31'd0, hartIf.exec_req}, 32'd1);
        checkOutput("pe_data0_we", {31'd0, data0We}, 32'd1);
        tick();
        tick();
        checkOutput("pe_exec_req_held", {31'd0, hartIf.exec_req}, 32'd1);
        hartIf.exec_ack = 1'b1;
        tick();
        hartIf.exec_ack = 1'b0;
        checkOutput("pe_wait_busy", {31'd0, busy}, 32'd1);
        checkOutput("pe_exec_req_dropped", {31'd0, hartIf.exec_req}, 32'd0);
        hartIf.exec_done      = 1'b1;
        hartIf.exec_exception = 1'b1;
        tick();
        hartIf.exec_done      = 1'b0;
        hartIf.exec_exception = 1'b0;
        checkOutput("pe_done_busy", {31'd0, busy}, 32'd0);
        checkOutput("pe_exception", {29'd0, cmderr}, 32'd3);
        clearErrors();

        // Postexec only; done alongside ack is not seen.
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd2, 16'h0000);
        checkOutput("po_exec_req", {31'd0, hartIf.exec_req}, 32'd1);
        checkOutput("po_no_reg_req", {31'd0, hartIf.reg_req}, 32'd0);
        hartIf.exec_ack  = 1'b1;
        hartIf.exec_done = 1'b1;
        tick();
        hartIf.exec_ack = 1'b0;
        checkOutput("po_early_done_ignored", {31'd0, busy}, 32'd1);
        tick();
        hartIf.exec_done = 1'b0;
        checkOutput("po_done_busy", {31'd0, busy}, 32'd0);
        checkOutput("po_no_err", {29'd0, cmderr}, 32'd0);

        // New command during RESP with a same-cycle clear; read still finishes.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd2, 16'h1004);
        hartIf.reg_gnt = 1'b1;
        tick();
        hartIf.reg_gnt = 1'b0;
        writeCmd       = 1'b1;
        regNo          = 16'h2222;
        cmdValid       = 1'b1;
        cmderrClear    = 3'b111;
        tick();
        cmdValid    = 1'b0;
        cmderrClear = 3'b000;
        writeCmd    = 1'b0;
        checkOutput("bz_cmderr", {29'd0, cmderr}, 32'd1);
        checkOutput("bz_still_busy", {31'd0, busy}, 32'd1);
        hartIf.reg_rvalid = 1'b1;
        hartIf.reg_rdata  = 32'h600D_F00D;
        expectedData0.push_back(32'h600D_F00D);
        tick();
        hartIf.reg_rvalid = 1'b0;
        checkOutput("bz_data0_we", {31'd0, data0We}, 32'd1);
        checkOutput("bz_done_busy", {31'd0, busy}, 32'd0);
        clearErrors();

        // Register error on a read with postexec: no exec, no write-back.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd2, 16'h1005);
        hartIf.reg_gnt = 1'b1;
        tick();
        hartIf.reg_gnt    = 1'b0;
        hartIf.reg_rvalid = 1'b1;
        hartIf.reg_err    = 1'b1;
        hartIf.reg_rdata  = 32'h0000_0BAD;
        tick();
        hartIf.reg_rvalid = 1'b0;
        hartIf.reg_err    = 1'b0;
        checkOutput("re_cmderr", {29'd0, cmderr}, 32'd3);
        checkOutput("re_busy", {31'd0, busy}, 32'd0);
        checkOutput("re_no_exec", {31'd0, hartIf.exec_req}, 32'd0);
        checkOutput("re_no_data0_we", {31'd0, data0We}, 32'd0);
        tick();
        checkOutput("re_no_exec_later", {31'd0, hartIf.exec_req}, 32'd0);
        clearErrors();

        // Asynchronous reset while in REQ clears every output at once.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd2, 16'h1006);
        checkOutput("rst_pre_req", {31'd0, hartIf.reg_req}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_req", {31'd0, hartIf.reg_req}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_addr", {16'd0, hartIf.reg_addr}, 32'd0);
        checkOutput("rst_data0", data0Out, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("rst_idle_after", {31'd0, busy}, 32'd0);

        checkOutput("scoreboard_drained", expectedData0.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failureCount);
        $finish;
    end

endmodule
